// File: rtl/dmux_stream_pkg.sv
// dmux_stream_pkg: shared word width and destination range helper for the stream demux
package dmux_stream_pkg;
  localparam int WORD_W = 16;
  function automatic logic sel_in_range(input int sel, input int channels);
    return sel < channels;
  endfunction
endpackage

// File: rtl/dmux_stream_slot.sv
// dmux_stream_slot: one-entry holding register (clk, reset, load, drain, d -> q, valid)
module dmux_stream_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  logic [WIDTH-1:0] data_d, data_q;
  logic valid_d, valid_q;
  always_comb begin
    valid_d = load | (valid_q & ~drain);
    data_d = load ? d : data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign q = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/dmux_stream.sv
// dmux_stream: N-way registered stream demux (in_data/in_sel/in_bcast/in_valid -> in_ready; out_data/out_valid per channel, out_ready; err, drop_cnt)
module dmux_stream import dmux_stream_pkg::*; #(
  parameter int WIDTH = WORD_W,
  parameter int CHANNELS = 8,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err,
  output logic [CNT_W-1:0]          drop_cnt
);
  logic [CHANNELS-1:0] free, load;
  logic sel_ok, accept, err_d, err_q;
  logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;
  always_comb begin
    free = ~out_valid | out_ready;
    sel_ok = sel_in_range(32'(in_sel), CHANNELS);
    in_ready = in_bcast ? &free : sel_ok ? free[in_sel] : 1'b1;
    accept = in_valid & in_ready;
    for (int i = 0; i < CHANNELS; i++) load[i] = accept & (in_bcast | (sel_ok & (32'(in_sel) == i)));
    err_d = accept & ~in_bcast & ~sel_ok;
    drop_cnt_d = (err_d & ~&drop_cnt_q) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    dmux_stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .drain (out_ready[k]),
      .d     (in_data),
      .q     (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k])
    );
  end
  assign err = err_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed checks of dmux_stream with 8 and 6 channels
module tb_dmux_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] a_in_data = '0;
  logic [2:0] a_in_sel = '0;
  logic a_in_bcast = 1'b0, a_in_valid = 1'b0, a_in_ready, a_err;
  logic [127:0] a_out_data;
  logic [7:0] a_out_valid, a_out_ready = 8'hff, a_drop_cnt;
  logic [15:0] b_in_data = '0;
  logic [2:0] b_in_sel = '0;
  logic b_in_bcast = 1'b0, b_in_valid = 1'b0, b_in_ready, b_err;
  logic [95:0] b_out_data;
  logic [5:0] b_out_valid, b_out_ready = 6'h3f;
  logic [7:0] b_drop_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmux_stream #(.WIDTH(16), .CHANNELS(8), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_sel(a_in_sel), .in_bcast(a_in_bcast),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .err(a_err), .drop_cnt(a_drop_cnt)
  );

  dmux_stream #(.WIDTH(16), .CHANNELS(6), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err(b_err), .drop_cnt(b_drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", a_out_valid, 8'h00);
    chk("rst_data", a_out_data, '0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_cnt", a_drop_cnt, 8'd0);
    reset = 1'b0;
    tick();
    // unicast to channel 3
    a_in_sel = 3'd3; a_in_data = 16'hbeef; a_in_valid = 1'b1;
    #1 chk("uni_ready", a_in_ready, 1'b1);
    tick();
    a_in_valid = 1'b0;
    chk("uni_valid", a_out_valid, 8'h08);
    chk("uni_data", a_out_data[3*16 +: 16], 16'hbeef);
    tick();
    chk("uni_drain", a_out_valid, 8'h00);
    // backpressure on channel 5
    a_out_ready = 8'hdf;
    a_in_sel = 3'd5; a_in_data = 16'h5555; a_in_valid = 1'b1;
    tick();
    chk("bp_fill", a_out_valid, 8'h20);
    a_in_data = 16'h6666;
    #1 chk("bp_blocked", a_in_ready, 1'b0);
    tick();
    chk("bp_hold_v", a_out_valid, 8'h20);
    chk("bp_hold_d", a_out_data[5*16 +: 16], 16'h5555);
    a_in_sel = 3'd2; a_in_data = 16'h2222;
    #1 chk("bp_other_ready", a_in_ready, 1'b1);
    tick();
    chk("bp_other_v", a_out_valid, 8'h24);
    chk("bp_other_d", a_out_data[2*16 +: 16], 16'h2222);
    a_in_sel = 3'd5; a_in_data = 16'h6666;
    #1 chk("bp_blocked2", a_in_ready, 1'b0);
    a_out_ready = 8'hff;
    #1 chk("bp_release", a_in_ready, 1'b1);
    tick();
    a_in_valid = 1'b0;
    chk("bp_refill_v", a_out_valid, 8'h20);
    chk("bp_refill_d", a_out_data[5*16 +: 16], 16'h6666);
    tick();
    chk("bp_empty", a_out_valid, 8'h00);
    // broadcast with channel 6 stalled
    a_out_ready = 8'hbf;
    a_in_sel = 3'd6; a_in_data = 16'h7777; a_in_valid = 1'b1;
    tick();
    a_in_bcast = 1'b1; a_in_data = 16'h1234;
    #1 chk("bc_blocked", a_in_ready, 1'b0);
    tick();
    chk("bc_none_v", a_out_valid, 8'h40);
    chk("bc_none_d", a_out_data[6*16 +: 16], 16'h7777);
    a_out_ready = 8'hff;
    #1 chk("bc_release", a_in_ready, 1'b1);
    tick();
    a_in_valid = 1'b0; a_in_bcast = 1'b0;
    chk("bc_all_v", a_out_valid, 8'hff);
    for (int i = 0; i < 8; i++) chk($sformatf("bc_d%0d", i), a_out_data[i*16 +: 16], 16'h1234);
    tick();
    chk("bc_drain", a_out_valid, 8'h00);
    // back-to-back streaming into channel 0
    a_in_sel = 3'd0; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_data = 16'ha0 + 16'(i);
      #1 chk($sformatf("st_ready%0d", i), a_in_ready, 1'b1);
      tick();
      chk($sformatf("st_valid%0d", i), a_out_valid, 8'h01);
      chk($sformatf("st_data%0d", i), a_out_data[15:0], 16'ha0 + 16'(i));
    end
    a_in_valid = 1'b0;
    tick();
    chk("st_empty", a_out_valid, 8'h00);
    // invalid destination on a 6-channel instance
    b_in_sel = 3'd7; b_in_data = 16'hdead; b_in_valid = 1'b1;
    #1 chk("inv_ready", b_in_ready, 1'b1);
    tick();
    b_in_valid = 1'b0;
    chk("inv_err", b_err, 1'b1);
    chk("inv_cnt", b_drop_cnt, 8'd1);
    chk("inv_no_valid", b_out_valid, 6'h00);
    tick();
    chk("inv_err_pulse", b_err, 1'b0);
    chk("inv_cnt_hold", b_drop_cnt, 8'd1);
    b_in_valid = 1'b1;
    repeat (253) tick();
    chk("inv_cnt254", b_drop_cnt, 8'd254);
    repeat (46) tick();
    b_in_valid = 1'b0;
    chk("inv_sat", b_drop_cnt, 8'd255);
    chk("inv_sat_no_valid", b_out_valid, 6'h00);
    b_in_sel = 3'd4; b_in_data = 16'h4444; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk("b_uni_v", b_out_valid, 6'h10);
    chk("b_uni_err", b_err, 1'b0);
    // asynchronous reset mid-cycle with all slots full
    a_out_ready = 8'h00;
    a_in_bcast = 1'b1; a_in_data = 16'h9999; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in_bcast = 1'b0;
    chk("ar_full", a_out_valid, 8'hff);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", a_out_valid, 8'h00);
    chk("ar_data", a_out_data, '0);
    chk("ar_cnt", b_drop_cnt, 8'd0);
    chk("ar_bvalid", b_out_valid, 6'h00);
    tick();
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
